// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding, default depth and
// the word indices of the exception vectors reachable through the IorD mux.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int MEM_DEPTH_DEFAULT = 256;

  localparam int EXC_VEC_IDX0 = 253;
  localparam int EXC_VEC_IDX1 = 254;
  localparam int EXC_VEC_IDX2 = 255;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the datapath (master) and the memory responder (slave).
interface mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_word_ram.sv
// Word-wide storage: synchronous write, combinational read. Contents survive reset.
module mem_word_ram #(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= wdata;
    end
  end

  assign rdata = r_mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one word request, waits LATENCY cycles, performs
// the access and returns a single-cycle response carrying read data or an error.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = MEM_DEPTH_DEFAULT,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);

  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [2:0]  LAT       = 3'(LATENCY);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH);

  state_t      r_state;
  state_t      w_next_state;
  logic [2:0]  r_cnt;
  logic [2:0]  w_next_cnt;
  logic [31:0] r_addr;
  logic        r_we;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic             w_ready;
  logic             w_resp_valid;
  logic             w_ram_we;
  logic             w_err;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_ram_rdata;

  // Range check uses the full word address so out-of-range requests never alias.
  assign w_err = (r_addr[1:0] != 2'b00) || (r_addr[31:2] >= DEPTH_LIM);
  assign w_idx = r_addr[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_ready      = 1'b0;
    w_resp_valid = 1'b0;
    w_ram_we     = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (bus.req_valid) begin
          if (LATENCY == 0) begin
            w_next_state = ACCESS;
          end else begin
            w_next_state = WAIT;
            w_next_cnt   = LAT;
          end
        end
      end
      WAIT: begin
        w_next_cnt = r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        // Gating with reset keeps an aborted write from landing at the access edge.
        w_ram_we     = r_we && !w_err && reset;
        w_next_state = RESP;
      end
      RESP: begin
        w_resp_valid = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr  <= 32'd0;
      r_we    <= 1'b0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.req_valid) begin
        r_addr  <= bus.req_addr;
        r_we    <= bus.req_we;
        r_wdata <= bus.req_wdata;
      end
      if (r_state == ACCESS) begin
        r_err   <= w_err;
        r_rdata <= (w_err || r_we) ? 32'd0 : w_ram_rdata;
      end
    end
  end

  mem_word_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .idx   (w_idx),
    .wdata (r_wdata),
    .rdata (w_ram_rdata)
  );

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

endmodule
